// File: rtl/alu_miter_sweeper_if.sv
// +----------------------------------------------------------------------+
// | alu_miter_sweeper_if                                                  |
// | Shared stimulus / result bundle between the sweeper and an ALU pair.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_miter_sweeper_if #(
  parameter int WIDTH    = 16,
  parameter int OPCODE_W = 8,
  parameter int FLAG_W   = 5
);
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic [OPCODE_W-1:0] Opcode;
  logic                CarryIn;
  logic [WIDTH-1:0]    ResultRef;
  logic [WIDTH-1:0]    ResultDut;
  logic [FLAG_W-1:0]   FlagsRef;
  logic [FLAG_W-1:0]   FlagsDut;

  modport master (
    output A, B, Opcode, CarryIn,
    input  ResultRef, ResultDut, FlagsRef, FlagsDut
  );

  modport slave (
    input  A, B, Opcode, CarryIn,
    output ResultRef, ResultDut, FlagsRef, FlagsDut
  );
endinterface

`default_nettype wire

// File: rtl/alu_miter_sweeper.sv
// +----------------------------------------------------------------------+
// | alu_miter_sweeper                                                     |
// | LFSR opcode sweep into a reference/DUT ALU pair with aligned compare. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_miter_sweeper #(
  parameter int          WIDTH    = 16,
  parameter int          OPCODE_W = 8,
  parameter int          OP_FIRST = 0,
  parameter int          OP_LAST  = 255,
  parameter int          ITERS    = 10,
  parameter int          LATENCY  = 0,
  parameter int          FLAG_W   = 5,
  parameter logic [31:0] SEED     = 32'hACE1_2011,
  parameter int          CNT_W    = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  alu_miter_sweeper_if.master    alu,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Pass,
  output logic [CNT_W-1:0]       MismatchCount,
  output logic                   FirstFailValid,
  output logic [WIDTH-1:0]       FirstFailA,
  output logic [WIDTH-1:0]       FirstFailB,
  output logic [OPCODE_W-1:0]    FirstFailOpcode,
  output logic                   FirstFailCarry
);

  localparam int          ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam bit          DEGEN  = (OP_FIRST > OP_LAST);
  localparam logic [31:0] C_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [31:0]          r_lfsr_a;
  logic [31:0]          r_lfsr_b;
  logic [OPCODE_W-1:0]  r_op;
  logic [ITER_W-1:0]    r_iter;

  // Index 0 is the registered output stage; index LATENCY lines up with the ALU results.
  logic [WIDTH-1:0]     r_dly_a  [0:LATENCY];
  logic [WIDTH-1:0]     r_dly_b  [0:LATENCY];
  logic [OPCODE_W-1:0]  r_dly_op [0:LATENCY];
  logic                 r_dly_c  [0:LATENCY];
  logic                 r_dly_v  [0:LATENCY];

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ff_valid;
  logic [WIDTH-1:0]     r_ff_a;
  logic [WIDTH-1:0]     r_ff_b;
  logic [OPCODE_W-1:0]  r_ff_op;
  logic                 r_ff_c;

  logic                 w_start;
  logic                 w_issue;
  logic                 w_last;
  logic                 w_mis;
  logic                 w_dly_busy;

  function automatic logic [31:0] f_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? C_TAPS : 32'h0);
  endfunction

  assign w_start = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue = (r_state == S_RUN) && !DEGEN;
  assign w_last  = (r_op == OPCODE_W'(OP_LAST)) && (r_iter == ITER_W'(ITERS - 1));
  assign w_mis   = r_dly_v[LATENCY] &&
                   ((alu.ResultRef != alu.ResultDut) || (alu.FlagsRef != alu.FlagsDut));

  always_comb begin
    w_dly_busy = 1'b0;
    for (int j = 0; j <= LATENCY; j++) begin
      w_dly_busy = w_dly_busy | r_dly_v[j];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) w_next = S_RUN;
      end
      S_RUN: begin
        if (DEGEN)       w_next = S_DONE;
        else if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_dly_busy) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lfsr_a   <= SEED;
      r_lfsr_b   <= ~SEED;
      r_op       <= '0;
      r_iter     <= '0;
      r_cnt      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_op    <= '0;
      r_ff_c     <= 1'b0;
      for (int j = 0; j <= LATENCY; j++) begin
        r_dly_a[j]  <= '0;
        r_dly_b[j]  <= '0;
        r_dly_op[j] <= '0;
        r_dly_c[j]  <= 1'b0;
        r_dly_v[j]  <= 1'b0;
      end
    end else begin
      for (int j = 1; j <= LATENCY; j++) begin
        r_dly_a[j]  <= r_dly_a[j-1];
        r_dly_b[j]  <= r_dly_b[j-1];
        r_dly_op[j] <= r_dly_op[j-1];
        r_dly_c[j]  <= r_dly_c[j-1];
        r_dly_v[j]  <= r_dly_v[j-1];
      end
      r_dly_v[0] <= w_issue;

      if (w_issue) begin
        r_dly_a[0]  <= r_lfsr_a[WIDTH-1:0];
        r_dly_b[0]  <= r_lfsr_b[WIDTH-1:0];
        r_dly_c[0]  <= r_lfsr_a[31] ^ r_lfsr_b[31];
        r_dly_op[0] <= r_op;
        r_lfsr_a    <= f_step(r_lfsr_a);
        r_lfsr_b    <= f_step(r_lfsr_b);
        if (r_iter == ITER_W'(ITERS - 1)) begin
          r_iter <= '0;
          r_op   <= r_op + 1'b1;
        end else begin
          r_iter <= r_iter + 1'b1;
        end
      end

      if (w_mis) begin
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_a     <= r_dly_a[LATENCY];
          r_ff_b     <= r_dly_b[LATENCY];
          r_ff_op    <= r_dly_op[LATENCY];
          r_ff_c     <= r_dly_c[LATENCY];
        end
      end

      // Start only lands while idle or done, where the delay line is already empty.
      if (w_start) begin
        r_lfsr_a    <= SEED;
        r_lfsr_b    <= ~SEED;
        r_op        <= OPCODE_W'(OP_FIRST);
        r_iter      <= '0;
        r_dly_op[0] <= OPCODE_W'(OP_FIRST);
        r_cnt       <= '0;
        r_ff_valid  <= 1'b0;
        r_ff_a      <= '0;
        r_ff_b      <= '0;
        r_ff_op     <= '0;
        r_ff_c      <= 1'b0;
      end
    end
  end

  assign alu.A       = r_dly_a[0];
  assign alu.B       = r_dly_b[0];
  assign alu.Opcode  = r_dly_op[0];
  assign alu.CarryIn = r_dly_c[0];

  assign Busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign Done            = (r_state == S_DONE);
  assign Pass            = Done && (r_cnt == '0);
  assign MismatchCount   = r_cnt;
  assign FirstFailValid  = r_ff_valid;
  assign FirstFailA      = r_ff_a;
  assign FirstFailB      = r_ff_b;
  assign FirstFailOpcode = r_ff_op;
  assign FirstFailCarry  = r_ff_c;

endmodule

`default_nettype wire

// File: doc/alu_miter_sweeper.md
Name: alu_miter_sweeper

Overview:
- Synthesizable stimulus and compare engine for ALU equivalence checking.
- Drives one shared A/B/Opcode/CarryIn vector into a reference ALU and an ALU under test.
- Sweeps an opcode range with a parametrised number of pseudo-random vectors per opcode, aligns results through a programmable-latency pipeline, and counts mismatches.
- Captures the first failing vector for on-board debug; sits beside the ALU pair in the hardware self-test wrapper.

Parameters:
- WIDTH, 16, operand/result width (1..32)
- OPCODE_W, 8, opcode width
- OP_FIRST, 0, first opcode swept
- OP_LAST, 255, last opcode swept (inclusive)
- ITERS, 10, vectors per opcode (>=1)
- LATENCY, 0, DUT result latency in clocks (0..7), identical for both ALUs
- FLAG_W, 5, flag bits compared alongside result
- SEED, 32'hACE1_2011, LFSR seed (nonzero)
- CNT_W, 16, mismatch counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse, begins a sweep
- A  out  WIDTH  operand A to both ALUs
- B  out  WIDTH  operand B to both ALUs
- Opcode  out  OPCODE_W  opcode to both ALUs
- CarryIn  out  1  carry to both ALUs
- ResultRef  in  WIDTH  reference ALU result
- ResultDut  in  WIDTH  ALU-under-test result
- FlagsRef  in  FLAG_W  reference flags
- FlagsDut  in  FLAG_W  DUT flags
- Busy  out  1  sweep in progress
- Done  out  1  sweep complete, held until next Start
- Pass  out  1  Done and MismatchCount==0
- MismatchCount  out  CNT_W  saturating mismatch count
- FirstFailValid  out  1  first-fail capture holds data
- FirstFailA  out  WIDTH  captured A
- FirstFailB  out  WIDTH  captured B
- FirstFailOpcode  out  OPCODE_W  captured opcode
- FirstFailCarry  out  1  captured CarryIn

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE.
  - All outputs 0: A, B, Opcode, CarryIn, Busy, Done, Pass, MismatchCount, FirstFail*.
  - LFSR_A=SEED, LFSR_B=~SEED.
  - Delay-line valid bits cleared.
- LFSRs: 32-bit Galois, taps 32'h8020_0003, each steps once per issued vector.
  - A=LFSR_A[WIDTH-1:0], B=LFSR_B[WIDTH-1:0], CarryIn=LFSR_A[31]^LFSR_B[31].
- States: IDLE, RUN, DRAIN, DONE.
- IDLE / DONE + Start:
  - MismatchCount and FirstFail* cleared, LFSRs reseeded, Opcode=OP_FIRST, iter=0.
  - Next state RUN; Busy=1, Done=0.
- RUN: one new vector registered onto A/B/Opcode/CarryIn every clock; a valid bit enters the delay line with it.
  - iter increments; at iter==ITERS-1, iter returns to 0 and Opcode increments.
  - The vector with Opcode==OP_LAST and iter==ITERS-1 is the last one. Termination uses an equality compare, so OP_LAST=2^OPCODE_W-1 must not wrap.
  - After the last vector, go to DRAIN.
- Degenerate range: if OP_FIRST>OP_LAST, RUN issues no vectors and goes to DONE on the next clock. Count stays 0, Pass=1.
- Compare:
  - Stimulus plus valid bit are delayed LATENCY+1 clocks (one registered output stage plus LATENCY).
  - ResultRef/ResultDut and FlagsRef/FlagsDut are sampled on the clock when the delayed valid is 1.
  - Mismatch = results differ or flags differ.
  - On a mismatch, MismatchCount increments, saturating at all-ones.
  - On the first mismatch only, the delayed stimulus loads into FirstFail* and FirstFailValid=1.
- DRAIN: no new vectors; A/B/Opcode/CarryIn hold the last values. Leave when the delay line is empty (LATENCY+1 clocks), then DONE.
- DONE: Busy=0, Done=1, Pass=(MismatchCount==0). Counters and captures hold.
- Total sweep time: N=(OP_LAST-OP_FIRST+1)*ITERS vectors; Done rises N+LATENCY+2 clocks after the Start clock.
- Start while Busy is ignored.
- Reset mid-sweep aborts immediately to reset values; no partial results are retained.

Test Plan:
- ALU under test tied to the reference ALU, OP_FIRST=6, OP_LAST=7, ITERS=10, LATENCY=0; pulse Start → 20 vectors, Done at clock 22, MismatchCount=0, Pass=1.
- ResultDut=ResultRef^16'h0001 only when Opcode==7, same params → MismatchCount=10, Pass=0, FirstFailOpcode=7, FirstFailA/B match the 11th LFSR vector.
- LATENCY=3, both ALUs registered through 3 stages, identical → MismatchCount=0. Repeat with the DUT delayed 4 stages → mismatch count nonzero, proving alignment.
- OP_FIRST=254, OP_LAST=255, ITERS=2, OPCODE_W=8 → exactly 4 vectors, opcodes 254,254,255,255, sweep terminates (no wrap to 0).
- CNT_W=3, DUT always wrong, 20 vectors → MismatchCount saturates at 7. Start during RUN is ignored; Start after Done reruns identical vectors (same seed).
- Assert Reset_n=0 mid-RUN at vector 5 → all outputs 0 asynchronously. Release and pulse Start → full clean sweep, Pass=1.
